bt_cmd_decoder: RTL

- Sits directly downstream of the Bluetooth receive stage.
- Consumes the 32-bit word and `refresh` strobe from `recv_8byte`, decodes the word as a DDS command, and drives the registered DDS control words (frequency tuning word, waveform select, amplitude scale, phase offset) to the DDS core.
- Frequency commands are converted from Hz to a tuning word by a sequential shift-add multiplier.
- Bad or overrun commands raise an error pulse, which the response path uses to choose its reply.

---
 rtl/bt_cmd_pkg.sv | 60 ++++++
 rtl/bt_seq_mult.sv | 94 +++++++++
 rtl/bt_cmd_decoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bt_cmd_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bt_cmd_pkg
//
// Shared definitions for the Bluetooth DDS command decoder:
//   - default numeric parameters (payload width, tuning constant, shift, clamp)
//   - command opcodes carried in word bits [31:28]
//   - decoder FSM state encoding
//   - waveform select codes driven to the DDS core
//   - reset values of the DDS control outputs
//   - payload range helper used by the decoder
// -----------------------------------------------------------------------------
package bt_cmd_pkg;

  // Frequency payload width in Hz (word bits [27:0]).
  localparam int DEF_FREQ_W    = 28;
  // round(2^32 / 50 MHz * 2^8): Hz -> phase increment, pre-scaled by 2^8.
  localparam int DEF_FTW_K     = 21990;
  localparam int DEF_FTW_SHIFT = 8;
  // Highest frequency the DDS is allowed to synthesise, in Hz.
  localparam int DEF_MAX_FREQ  = 20000000;
  // Multiplicand width for the tuning constant; 16 bits hold DEF_FTW_K.
  localparam int DEF_MUL_B_W   = 16;

  // Command opcodes.
  localparam logic [3:0] OP_FREQ  = 4'd1;
  localparam logic [3:0] OP_WAVE  = 4'd2;
  localparam logic [3:0] OP_AMP   = 4'd3;
  localparam logic [3:0] OP_PHASE = 4'd4;

  // Decoder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_MUL    = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Waveform select codes understood by the DDS core.
  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_e;

  // Output values after reset: silent frequency, full-scale sine, no offset.
  localparam logic [31:0] RST_FREQ_WORD  = 32'd0;
  localparam logic [1:0]  RST_WAVE_SEL   = WAVE_SINE;
  localparam logic [7:0]  RST_AMP_SCALE  = 8'hFF;
  localparam logic [11:0] RST_PHASE_WORD = 12'd0;

  // True when the payload fits in the low 'width' bits, i.e. it is within the
  // range of the target control register.
  function automatic logic payload_fits(input logic [27:0] payload,
                                        input int unsigned width);
    return (payload >> width) == 28'd0;
  endfunction

endpackage

// File: rtl/bt_seq_mult.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bt_seq_mult
//
// Serial shift-add multiplier with a start/done handshake. One multiplier bit
// is examined per cycle, LSB first; when set, the (progressively left-shifted)
// multiplicand is added into an (A_W + B_W)-bit accumulator. A_W cycles after
// the start cycle the full product is held in the accumulator.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset; aborts any run in progress
//   start   in   one-cycle request; loads a and b, clears the accumulator
//   a       in   A_W-bit multiplier (bits consumed LSB first)
//   b       in   B_W-bit multiplicand
//   done    out  high during the cycle in which the last partial product is
//                added; result is valid from the following cycle until the
//                next start
//   result  out  (product >> SHIFT) truncated to R_W bits
// -----------------------------------------------------------------------------
module bt_seq_mult #(
  parameter int A_W   = 28,
  parameter int B_W   = 16,
  parameter int SHIFT = 8,
  parameter int R_W   = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           done,
  output logic [R_W-1:0] result
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(A_W + 1);

  logic             running_q, running_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [A_W-1:0]   mplier_q,  mplier_d;
  logic [P_W-1:0]   mcand_q,   mcand_d;
  logic [P_W-1:0]   acc_q,     acc_d;

  assign done   = running_q && (cnt_q == CNT_W'(A_W - 1));
  assign result = R_W'(acc_q >> SHIFT);

  always_comb begin
    // NOTE: every variable gets a default before any branch so the block
    // stays purely combinational; a missing path would infer a latch.
    running_d = running_q;
    cnt_d     = cnt_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;

    if (start) begin
      running_d = 1'b1;
      cnt_d     = '0;
      mplier_d  = a;
      mcand_d   = P_W'(b);
      acc_d     = '0;
    end else if (running_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mplier_d = mplier_q >> 1;
      mcand_d  = mcand_q << 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (done) begin
        running_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      mplier_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: rtl/bt_cmd_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bt_cmd_decoder
//
// Decodes 32-bit command words from the Bluetooth receive stage into the
// registered DDS control words. Word format: opcode [31:28], payload [27:0].
//   opcode 1  frequency in Hz -> freq_word = (payload * FTW_K) >> FTW_SHIFT
//   opcode 2  waveform select  (payload <= 3)
//   opcode 3  amplitude scale  (payload <= 255)
//   opcode 4  phase offset     (payload <= 4095)
// Anything else is rejected with a cmd_err pulse. A new word arriving while a
// command is in flight is dropped and reported with cmd_err.
//
// Build option: define BT_CMD_FREQ_CLAMP_EN to clamp frequency payloads above
// MAX_FREQ to MAX_FREQ; without it such payloads are rejected.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   data_32bit  in   command word, stable while refresh is high
//   refresh     in   new-word strobe (pulse or held level)
//   freq_word   out  DDS phase-increment word
//   wave_sel    out  waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth
//   amp_scale   out  amplitude multiplier
//   phase_word  out  phase offset
//   cmd_valid   out  one-cycle pulse when a control register was updated
//   cmd_err     out  one-cycle pulse on a rejected or overrun command
//   busy        out  high whenever the decoder is not idle
// -----------------------------------------------------------------------------
module bt_cmd_decoder
  import bt_cmd_pkg::*;
#(
  parameter int FREQ_W    = DEF_FREQ_W,
  parameter int FTW_K     = DEF_FTW_K,
  parameter int FTW_SHIFT = DEF_FTW_SHIFT,
  parameter int MAX_FREQ  = DEF_MAX_FREQ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_32bit,
  input  logic        refresh,
  output logic [31:0] freq_word,
  output logic [1:0]  wave_sel,
  output logic [7:0]  amp_scale,
  output logic [11:0] phase_word,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic        busy
);

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  state_e      state_q,      state_d;
  logic        refresh_q,    refresh_d;
  logic [31:0] word_q,       word_d;
  logic [31:0] freq_word_q,  freq_word_d;
  logic [1:0]  wave_sel_q,   wave_sel_d;
  logic [7:0]  amp_scale_q,  amp_scale_d;
  logic [11:0] phase_word_q, phase_word_d;
  logic        cmd_valid_q,  cmd_valid_d;
  logic        cmd_err_q,    cmd_err_d;
  // Overrun error held back one cycle because it landed on a COMMIT edge.
  logic        ovr_pend_q,   ovr_pend_d;

  // ---------------------------------------------------------------------------
  // Strobe edge detection
  // ---------------------------------------------------------------------------
  logic refresh_rise;
  logic capture;
  logic overrun;

  // A held refresh level yields one rising edge, hence one capture.
  assign refresh_rise = refresh && !refresh_q;
  assign capture      = refresh_rise && (state_q == ST_IDLE);
  assign overrun      = refresh_rise && (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Command decode (from the latched word, stable through DECODE..COMMIT)
  // ---------------------------------------------------------------------------
  logic [3:0]        opcode;
  logic [27:0]       payload;
  logic              cmd_ok;
  logic [FREQ_W-1:0] mul_a;
  logic              mul_start;
  logic              mul_done;
  logic [31:0]       mul_result;

  assign opcode  = word_q[31:28];
  assign payload = word_q[27:0];

  always_comb begin
    cmd_ok = 1'b0;
    mul_a  = FREQ_W'(payload);
    case (opcode)
      OP_FREQ: begin
`ifdef BT_CMD_FREQ_CLAMP_EN
        cmd_ok = 1'b1;
        if (payload > 28'(MAX_FREQ)) begin
          mul_a = FREQ_W'(MAX_FREQ);
        end
`else
        cmd_ok = (payload <= 28'(MAX_FREQ));
`endif
      end
      OP_WAVE:  cmd_ok = payload_fits(payload, 2);
      OP_AMP:   cmd_ok = payload_fits(payload, 8);
      OP_PHASE: cmd_ok = payload_fits(payload, 12);
      default:  cmd_ok = 1'b0;
    endcase
  end

  // Only accepted frequency commands pay for the multiply; everything else
  // goes straight from DECODE to COMMIT.
  assign mul_start = (state_q == ST_DECODE) && (opcode == OP_FREQ) && cmd_ok;

  bt_seq_mult #(
    .A_W   (FREQ_W),
    .B_W   (DEF_MUL_B_W),
    .SHIFT (FTW_SHIFT),
    .R_W   (32)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (mul_a),
    .b      (DEF_MUL_B_W'(FTW_K)),
    .done   (mul_done),
    .result (mul_result)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (capture) state_d = ST_DECODE;
      ST_DECODE: state_d = mul_start ? ST_MUL : ST_COMMIT;
      // The multiplier raises done in its last add cycle, so MUL lasts
      // exactly FREQ_W cycles and the product is ready in COMMIT.
      ST_MUL:    if (mul_done) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / register-update logic
  // ---------------------------------------------------------------------------
  always_comb begin
    refresh_d    = refresh;
    word_d       = capture ? data_32bit : word_q;
    freq_word_d  = freq_word_q;
    wave_sel_d   = wave_sel_q;
    amp_scale_d  = amp_scale_q;
    phase_word_d = phase_word_q;
    cmd_valid_d  = 1'b0;
    cmd_err_d    = ovr_pend_q;
    ovr_pend_d   = 1'b0;

    // A dropped word is reported in the next cycle, unless that cycle already
    // carries the in-flight command's pulse; then it waits one more cycle so
    // the two pulses stay distinct.
    if (overrun) begin
      if (state_q == ST_COMMIT) begin
        ovr_pend_d = 1'b1;
      end else begin
        cmd_err_d = 1'b1;
      end
    end

    if (state_q == ST_COMMIT) begin
      if (cmd_ok) begin
        cmd_valid_d = 1'b1;
        case (opcode)
          OP_FREQ:  freq_word_d  = mul_result;
          OP_WAVE:  wave_sel_d   = payload[1:0];
          OP_AMP:   amp_scale_d  = payload[7:0];
          OP_PHASE: phase_word_d = payload[11:0];
          default:  cmd_valid_d  = 1'b1;
        endcase
      end else begin
        cmd_err_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q    <= 1'b0;
      word_q       <= 32'd0;
      freq_word_q  <= RST_FREQ_WORD;
      wave_sel_q   <= RST_WAVE_SEL;
      amp_scale_q  <= RST_AMP_SCALE;
      phase_word_q <= RST_PHASE_WORD;
      cmd_valid_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      ovr_pend_q   <= 1'b0;
    end else begin
      refresh_q    <= refresh_d;
      word_q       <= word_d;
      freq_word_q  <= freq_word_d;
      wave_sel_q   <= wave_sel_d;
      amp_scale_q  <= amp_scale_d;
      phase_word_q <= phase_word_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_err_q    <= cmd_err_d;
      ovr_pend_q   <= ovr_pend_d;
    end
  end

  assign freq_word  = freq_word_q;
  assign wave_sel   = wave_sel_q;
  assign amp_scale  = amp_scale_q;
  assign phase_word = phase_word_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_err    = cmd_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
